// File: rtl/cam_frame_gen_if.sv
// Camera pixel bus between the frame generator (master) and a cam_read-style receiver (slave).
// Handshake: px_data is valid when href=1 and is sampled on the rising edge of pclk; there is no backpressure.
interface cam_frame_gen_if;
  logic       CAM_pclk;
  logic       CAM_href;
  logic       CAM_vsync;
  logic [7:0] CAM_px_data;

  modport master (output CAM_pclk, output CAM_href, output CAM_vsync, output CAM_px_data);
  modport slave  (input  CAM_pclk, input  CAM_href, input  CAM_vsync, input  CAM_px_data);
endinterface

// File: rtl/cam_frame_gen.sv
// OV7670-style camera emulator: RGB444 frames on the pclk/href/vsync byte bus.
// All bus outputs other than pclk change only on the clk edge where pclk falls.
module cam_frame_gen #(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int H_BLANK      = 144,
  parameter int VS_LINES     = 3,
  parameter int V_BP         = 17,
  parameter int V_FP         = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            pattern_sel,
  input  logic [11:0]           color_in,
  cam_frame_gen_if.master       cam,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic [2:0]            state_dbg
);
  localparam int LINE_TICKS  = 2 * CAM_SCREEN_X + H_BLANK;
  localparam int TOTAL_LINES = VS_LINES + V_BP + CAM_SCREEN_Y + V_FP;
  localparam int ACT_FIRST   = VS_LINES + V_BP;
  localparam int ACT_END     = ACT_FIRST + CAM_SCREEN_Y;
  localparam int COL_W       = $clog2(LINE_TICKS);
  localparam int LINE_W      = $clog2(TOTAL_LINES);
  localparam int BAR_W       = CAM_SCREEN_X / 8;
  localparam int BAR_CW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  typedef enum logic [2:0] {IDLE = 3'd0, VSYNC = 3'd1, VBP = 3'd2, ACTIVE = 3'd3, VFP = 3'd4} state_t;

  state_t              state;
  logic [COL_W-1:0]    col, nxt_col;
  logic [LINE_W-1:0]   line, nxt_line;
  logic [BAR_CW-1:0]   bar_cnt, nxt_bar_cnt;
  logic [2:0]          bar_idx, nxt_bar_idx;
  logic [1:0]          lat_sel;
  logic [11:0]         lat_color;
  logic                tick, col_last, frame_end, start, run_next;
  logic                nxt_href, nxt_vsync;
  logic [7:0]          nxt_data;
  logic [3:0]          x4, y4;
  logic [11:0]         pix, bar_color;

  assign state_dbg = state;

  // Everything below describes the position that becomes visible after this tick.
  always_comb begin
    tick      = cam.CAM_pclk;
    col_last  = (col == COL_W'(LINE_TICKS - 1));
    frame_end = (state == VFP) && col_last && (line == LINE_W'(TOTAL_LINES - 1));
    start     = en && ((state == IDLE) || frame_end);
    run_next  = start || ((state != IDLE) && !frame_end);

    nxt_col  = '0;
    nxt_line = '0;
    if (run_next && !start) begin
      nxt_col  = col_last ? '0 : col + COL_W'(1);
      nxt_line = col_last ? line + LINE_W'(1) : line;
    end

    nxt_vsync = run_next && (nxt_line < LINE_W'(VS_LINES));
    nxt_href  = run_next && (nxt_line >= LINE_W'(ACT_FIRST)) && (nxt_line < LINE_W'(ACT_END))
                && (nxt_col < COL_W'(2 * CAM_SCREEN_X));

    // Bar index advances by counting pixels within the line instead of dividing x.
    nxt_bar_cnt = bar_cnt;
    nxt_bar_idx = bar_idx;
    if (nxt_col == '0) begin
      nxt_bar_cnt = '0;
      nxt_bar_idx = '0;
    end else if (!nxt_col[0]) begin
      if (bar_cnt == BAR_CW'(BAR_W - 1)) begin
        nxt_bar_cnt = '0;
        nxt_bar_idx = bar_idx + 3'd1;
      end else begin
        nxt_bar_cnt = bar_cnt + BAR_CW'(1);
      end
    end

    unique case (nxt_bar_idx)
      3'd0:    bar_color = 12'hFFF;
      3'd1:    bar_color = 12'hFF0;
      3'd2:    bar_color = 12'h0FF;
      3'd3:    bar_color = 12'h0F0;
      3'd4:    bar_color = 12'hF0F;
      3'd5:    bar_color = 12'hF00;
      3'd6:    bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase

    x4 = 4'(nxt_col >> 1);
    y4 = 4'(nxt_line - LINE_W'(ACT_FIRST));
    unique case (lat_sel)
      2'd0:    pix = lat_color;
      2'd1:    pix = bar_color;
      2'd2:    pix = {x4, y4, 4'(x4 + y4)};
      default: pix = (x4[3] ^ y4[3]) ? 12'hFFF : 12'h000;
    endcase

    nxt_data = 8'h00;
    if (nxt_href) nxt_data = nxt_col[0] ? pix[7:0] : {4'h0, pix[11:8]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      col             <= '0;
      line            <= '0;
      bar_cnt         <= '0;
      bar_idx         <= '0;
      lat_sel         <= '0;
      lat_color       <= '0;
      cam.CAM_pclk    <= 1'b0;
      cam.CAM_href    <= 1'b0;
      cam.CAM_vsync   <= 1'b0;
      cam.CAM_px_data <= 8'h00;
      frame_done      <= 1'b0;
      frame_cnt       <= 16'h0000;
    end else begin
      cam.CAM_pclk <= ~cam.CAM_pclk;
      frame_done   <= 1'b0;
      if (tick) begin
        col             <= nxt_col;
        line            <= nxt_line;
        bar_cnt         <= nxt_bar_cnt;
        bar_idx         <= nxt_bar_idx;
        cam.CAM_href    <= nxt_href;
        cam.CAM_vsync   <= nxt_vsync;
        cam.CAM_px_data <= nxt_data;
        if (start) begin
          lat_sel   <= pattern_sel;
          lat_color <= color_in;
        end
        unique case (state)
          IDLE:    if (en) state <= VSYNC;
          VSYNC:   if (col_last && line == LINE_W'(VS_LINES - 1)) state <= VBP;
          VBP:     if (col_last && line == LINE_W'(ACT_FIRST - 1)) state <= ACTIVE;
          ACTIVE:  if (col_last && line == LINE_W'(ACT_END - 1)) state <= VFP;
          VFP: begin
            if (frame_end) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
              state      <= en ? VSYNC : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cam_frame_gen.sv
// Bench for cam_frame_gen at a reduced geometry: tick-level frame model, byte capture and literal pins.
module tb_cam_frame_gen;
  localparam int X     = 24;
  localparam int Y     = 10;
  localparam int HB    = 8;
  localparam int VS    = 1;
  localparam int VBPL  = 2;
  localparam int VFPL  = 1;
  localparam int L     = 2 * X + HB;
  localparam int ACT0  = VS + VBPL;
  localparam int NLINE = VS + VBPL + Y + VFPL;
  localparam int FRAME = NLINE * L;
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [11:0] color = 12'h000;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [2:0]  state_dbg;

  cam_frame_gen_if cam ();

  cam_frame_gen #(
    .CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .H_BLANK(HB),
    .VS_LINES(VS), .V_BP(VBPL), .V_FP(VFPL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(sel), .color_in(color),
    .cam(cam), .frame_done(frame_done), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: frame position as a single tick index
  logic        m_pclk = 1'b0;
  logic        m_run = 1'b0;
  logic        m_done = 1'b0;
  int          m_t = 0;
  int          m_sel = 0;
  logic [11:0] m_col = 12'h000;
  logic [15:0] m_cnt = 16'h0000;

  function automatic logic [11:0] exp_pix(input int s, input logic [11:0] c, input int x, input int y);
    case (s)
      0:       return c;
      1:       return BARS[x / (X / 8)];
      2:       return {4'(x % 16), 4'(y % 16), 4'((x + y) % 16)};
      default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pclk <= 1'b0; m_run <= 1'b0; m_done <= 1'b0; m_t <= 0;
      m_sel <= 0; m_col <= 12'h000; m_cnt <= 16'h0000;
    end else begin
      m_pclk <= ~m_pclk;
      m_done <= 1'b0;
      if (m_pclk) begin
        if (!m_run) begin
          if (en) begin m_run <= 1'b1; m_t <= 0; m_sel <= int'(sel); m_col <= color; end
        end else if (m_t == FRAME - 1) begin
          m_done <= 1'b1;
          m_cnt  <= m_cnt + 16'd1;
          if (en) begin m_t <= 0; m_sel <= int'(sel); m_col <= color; end
          else m_run <= 1'b0;
        end else begin
          m_t <= m_t + 1;
        end
      end
    end
  end

  function automatic logic [27:0] exp_vec();
    logic hr, vs;
    logic [7:0] d;
    logic [11:0] p;
    int ln, cl;
    hr = 1'b0; vs = 1'b0; d = 8'h00;
    if (m_run) begin
      ln = m_t / L;
      cl = m_t % L;
      vs = (ln < VS);
      if (ln >= ACT0 && ln < ACT0 + Y && cl < 2 * X) begin
        hr = 1'b1;
        p  = exp_pix(m_sel, m_col, cl / 2, ln - ACT0);
        d  = (cl % 2 == 0) ? {4'h0, p[11:8]} : p[7:0];
      end
    end
    return {m_pclk, hr, vs, d, m_done, m_cnt};
  endfunction

  // scoreboard: captured bytes of the current frame, as cam_read would store them
  logic [7:0] exp_q[$];
  logic       cap_pvs = 1'b0;
  always @(posedge cam.CAM_pclk) begin
    if (cam.CAM_vsync && !cap_pvs) exp_q.delete();
    cap_pvs <= cam.CAM_vsync;
    if (cam.CAM_href) exp_q.push_back(cam.CAM_px_data);
  end

  function automatic logic [15:0] cap_pix(input int x, input int y);
    int i;
    i = 2 * (x + X * y);
    if (i + 1 < exp_q.size()) return {exp_q[i], exp_q[i + 1]};
    return 16'hDEAD;
  endfunction

  // per-cycle compare plus frame timing monitor
  logic p_vs = 1'b0, p_hr = 1'b0, p_pc = 1'b0;
  int since = 0, vs_clk = 0, hr_cnt = 0, hclk = 0, gap = -1;
  int snap_vs = 0, snap_hr = 0, snap_hclk = 0, snap_gap = 0, snap_done = 0;
  int vs_rises = 0, done_pulses = 0, pclk_rises = 0;
  logic [27:0] act_v, exp_v;

  always @(negedge clk) begin
    act_v = {cam.CAM_pclk, cam.CAM_href, cam.CAM_vsync, cam.CAM_px_data, frame_done, frame_cnt};
    exp_v = exp_vec();
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL cycle_model t=%0t actual=0x%07h expected=0x%07h", $time, act_v, exp_v);
    end
    if (frame_done) begin
      snap_vs = vs_clk; snap_hr = hr_cnt; snap_hclk = hclk; snap_gap = gap; snap_done = since + 1;
      done_pulses++;
    end
    if (cam.CAM_vsync && !p_vs) begin
      since = 0; vs_clk = 0; hr_cnt = 0; hclk = 0; gap = -1; vs_rises++;
    end else begin
      since++;
    end
    if (cam.CAM_vsync) vs_clk++;
    if (cam.CAM_href) hclk++;
    if (cam.CAM_href && !p_hr) begin
      hr_cnt++;
      if (gap < 0) gap = since;
    end
    if (cam.CAM_pclk && !p_pc) pclk_rises++;
    p_vs = cam.CAM_vsync; p_hr = cam.CAM_href; p_pc = cam.CAM_pclk;
  end

  // driver tasks
  task automatic wait_vs_rise(input int max, input string nm);
    int r0;
    logic found;
    r0 = vs_rises; found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk); #1;
      if (vs_rises != r0) found = 1'b1;
    end
    chk(nm, found, 1);
  endtask

  task automatic wait_href_high(input int max);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk); #1;
      if (cam.CAM_href) found = 1'b1;
    end
    chk("href_seen", found, 1);
  endtask

  task automatic wait_done(input int max, input string nm);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (frame_done) found = 1'b1;
    end
    #1;
    chk(nm, found, 1);
  endtask

  task automatic check_frame(input int s, input logic [11:0] c, input int cnt);
    int bad;
    bad = 0;
    chk("frame_cnt", frame_cnt, cnt);
    chk("vsync_clks", snap_vs, 2 * VS * L);
    chk("first_href_gap", snap_gap, 2 * ACT0 * L);
    chk("href_pulses", snap_hr, Y);
    chk("href_clks", snap_hclk, 2 * 2 * X * Y);
    chk("done_after_start", snap_done, 2 * FRAME);
    chk("captured_bytes", exp_q.size(), 2 * X * Y);
    for (int yy = 0; yy < Y; yy++)
      for (int xx = 0; xx < X; xx++)
        if (cap_pix(xx, yy) !== {4'h0, exp_pix(s, c, xx, yy)}) bad++;
    chk("frame_pixels_bad", bad, 0);
  endtask

  int          pats [5];
  logic [11:0] cols [5];
  int          r0;

  initial begin
    pats[0] = 0; cols[0] = 12'hA5C;
    pats[1] = 2; cols[1] = 12'($urandom);
    pats[2] = 1; cols[2] = 12'($urandom);
    pats[3] = 3; cols[3] = 12'($urandom);
    pats[4] = int'($urandom_range(0, 3)); cols[4] = 12'($urandom);

    repeat (5) @(negedge clk);
    #1;
    chk("reset_outputs", {cam.CAM_pclk, cam.CAM_href, cam.CAM_vsync, cam.CAM_px_data, frame_done, frame_cnt}, 0);
    chk("reset_state", state_dbg, 0);
    rst = 1'b1;

    @(negedge clk); #1;
    r0 = pclk_rises;
    repeat (2000) @(negedge clk);
    #1;
    chk("idle_pclk_rises", pclk_rises - r0, 1000);
    chk("idle_done_pulses", done_pulses, 0);
    chk("idle_vsync_rises", vs_rises, 0);

    sel = 2'(pats[0]); color = cols[0]; en = 1'b1;
    wait_vs_rise(10, "first_vsync");
    for (int f = 0; f < 5; f++) begin
      repeat ($urandom_range(400, 1300)) @(negedge clk);
      if (f < 4) begin
        sel = 2'(pats[f + 1]); color = cols[f + 1];
      end else begin
        en = 1'b0; sel = ~sel; color = ~color;
      end
      wait_done(2000, "frame_done_seen");
      check_frame(pats[f], cols[f], f + 1);
      case (f)
        0: begin
          chk("solid_0_0", cap_pix(0, 0), 16'h0A5C);
          chk("solid_23_9", cap_pix(23, 9), 16'h0A5C);
        end
        1: begin
          chk("coord_5_3", cap_pix(5, 3), 16'h0538);
          chk("coord_15_1", cap_pix(15, 1), 16'h0F10);
          chk("coord_23_9", cap_pix(23, 9), 16'h0790);
        end
        2: begin
          chk("bars_x2", cap_pix(2, 0), 16'h0FFF);
          chk("bars_x3", cap_pix(3, 0), 16'h0FF0);
          chk("bars_x12", cap_pix(12, 5), 16'h0F0F);
          chk("bars_x23", cap_pix(23, 9), 16'h0000);
        end
        3: begin
          chk("check_8_0", cap_pix(8, 0), 16'h0FFF);
          chk("check_8_8", cap_pix(8, 8), 16'h0000);
          chk("check_0_8", cap_pix(0, 8), 16'h0FFF);
          chk("check_7_7", cap_pix(7, 7), 16'h0000);
        end
        default: ;
      endcase
    end

    r0 = vs_rises;
    repeat (400) @(negedge clk);
    #1;
    chk("idle_no_restart", vs_rises - r0, 0);
    chk("idle_bus_low", {cam.CAM_href, cam.CAM_vsync, cam.CAM_px_data}, 0);
    chk("idle_state", state_dbg, 0);
    chk("idle_frame_cnt", frame_cnt, 5);

    sel = 2'd3; en = 1'b1;
    wait_vs_rise(10, "vsync_before_reset");
    wait_href_high(2 * FRAME);
    repeat (3) @(negedge clk);
    chk("href_before_reset", cam.CAM_href, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midline_reset_outputs", {cam.CAM_pclk, cam.CAM_href, cam.CAM_vsync, cam.CAM_px_data, frame_done, frame_cnt}, 0);
    chk("midline_reset_state", state_dbg, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_vs_rise(10, "vsync_after_reset");
    chk("no_href_at_restart", cam.CAM_href, 0);
    repeat (500) @(negedge clk);
    en = 1'b0;
    wait_done(2000, "frame_done_after_reset");
    check_frame(3, 12'h000, 1);

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cam_frame_gen.md
Name: cam_frame_gen

Overview:
- Synthesisable OV7670-style camera emulator: the transmitting end of the camera pixel interface that cam_read receives.
- Drives CAM_pclk, CAM_href, CAM_vsync and CAM_px_data with RGB444 frames (2 bytes per pixel) at the QQVGA 160x120 geometry.
- Used in simulation benches and on-board self-test, replacing the physical camera ahead of cam_read and buffer_ram_dp.

Parameters:
- CAM_SCREEN_X, 160, active pixels per line.
- CAM_SCREEN_Y, 120, active lines per frame.
- H_BLANK, 144, pclk periods with href low after each line's active bytes.
- VS_LINES, 3, line periods with vsync high.
- V_BP, 17, blank line periods after vsync, before the first active line.
- V_FP, 10, blank line periods after the last active line.

Ports:
- clk  in  1  generator clock; CAM_pclk is derived as clk/2.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run request, sampled only at frame boundaries.
- pattern_sel  in  2  0 solid, 1 colour bars, 2 coordinate, 3 checkerboard.
- color_in  in  12  RGB444 colour for solid mode.
- CAM_pclk  out  1  emulated pixel clock.
- CAM_href  out  1  line-valid.
- CAM_vsync  out  1  frame sync, active high.
- CAM_px_data  out  8  byte stream.
- frame_done  out  1  one-clk pulse at the end of each frame.
- frame_cnt  out  16  completed frames, wraps at 0xFFFF->0.

Behaviour:
- Reset (rst=0, asynchronous): every output is 0 and the FSM is in IDLE. pclk toggling restarts at the first clk after release.
- CAM_pclk toggles on every clk edge, even in IDLE.
- All other outputs update only on the clk edge where CAM_pclk goes 1->0. They are therefore stable across every pclk rising edge. One "tick" = one pclk period = 2 clk.
- Line period: L = 2*CAM_SCREEN_X + H_BLANK ticks (464 at defaults).
- FSM states and transitions:
  - IDLE: outputs low. If en=1 at a tick, latch pattern_sel and color_in, go to VSYNC.
  - VSYNC: vsync=1 for VS_LINES*L ticks, then go to VBP.
  - VBP: V_BP*L ticks, then go to ACTIVE.
  - ACTIVE: CAM_SCREEN_Y lines. Each line has href=1 for 2*CAM_SCREEN_X ticks, then href=0 for H_BLANK ticks. After the last line's blank, go to VFP.
  - VFP: V_FP*L ticks. At the final tick, pulse frame_done for one clk and increment frame_cnt. Then go to VSYNC if en=1 (back-to-back frames, latching new settings), else IDLE.
- en, pattern_sel and color_in changes mid-frame are ignored until the next frame start.
- Counters: column tick counter (0..L-1), line counter (0..total lines-1). Total lines = VS_LINES+V_BP+CAM_SCREEN_Y+V_FP = 150; frame = 69600 ticks. Counter widths are derived from the parameters with $clog2.
- Pixel (x,y), x=tick/2 during href, is sent as:
  - first byte {4'h0, R}
  - second byte {G, B}
- CAM_px_data = 0 whenever href=0.
- Patterns (x, y are zero-based active coordinates):
  - 0, solid: color_in.
  - 1, colour bars: 8 bars, each CAM_SCREEN_X/8 pixels wide (20 at default). Bar index comes from a comparator/counter chain, no divider. Bar colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - 2, coordinate: R=x[3:0], G=y[3:0], B=(x+y)[3:0], modulo 16.
  - 3, checkerboard: (x[3]^y[3]) ? FFF : 000.
- Reset asserted mid-frame: immediate return to the all-zero state; frame_cnt clears; no frame_done pulse.

Test Plan:
- Reset hold, then en=0 for 2000 clk -> CAM_pclk period exactly 2 clk; href=vsync=px_data=0; frame_done never pulses.
- en=1, pattern 0, color_in=12'hA5C -> vsync high for 1392 ticks. First href rise is 9280 ticks after the vsync rise. Each line carries 160 pairs 0x0A,0x5C, with href high 320 ticks and low 144 ticks. There are 120 href pulses per frame.
- Pattern 2 -> line y=3, pixel x=5 bytes 0x05,0x38. Pixel (15,1) bytes 0x0F,0x10. All 19200 pixels must be captured correctly by cam_read into buffer_ram_dp at address x+160*y.
- Pattern 1 -> pixel x=19 bytes 0x0F,0xFF. Pixel x=20 bytes 0x0F,0xF0. Pixel x=159 bytes 0x00,0x00.
- Run, then drop en and change pattern_sel mid-ACTIVE -> the current frame completes with the old pattern. frame_done pulses 1 clk 69600 ticks after the frame start; frame_cnt increments by 1; FSM returns to IDLE with outputs low.
- Assert rst low mid-line with href=1 -> all outputs 0 within the same clk edge, frame_cnt=0. After release with en=1, the next frame starts with vsync.
